alu_result_fifo: RTL and testbench
==================================

// Module: alu_result_fifo
// PURPOSE
//  - Output stage downstream of the ALU result multiplexer.
//  - Captures each 4-bit final_result with its 3-bit opcode into a small FIFO.
//  - Presents the head entry, with a zero flag, over a valid/ready handshake to the consumer
//    (register file / display stage).
//  - Decouples ALU issue rate from consumer back-pressure.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of two, >=2
//  AW      2   pointer width = log2(DEPTH)
// PORTS
//  clk           in   1  rising-edge clock
//  rst_n         in   1  asynchronous active-low reset
//  in_valid      in   1  producer presents a result this cycle
//  in_ready      out  1  FIFO can accept (not full)
//  opcode        in   3  opcode that selected the result
//  final_result  in   4  multiplexed ALU result
//  out_valid     out  1  head entry available (not empty)
//  out_ready     in   1  consumer takes the head this cycle
//  out_data      out  4  head result
//  out_opcode    out  3  head opcode
//  out_zero      out  1  out_data == 4'h0 (qualified by out_valid, else 0)
//  count         out  AW+1  current occupancy 0..DEPTH
//  illegal_op    out  1  one-cycle pulse: reserved opcode 3'h6 dropped
// BEHAVIOUR
//  - Reset (async assert, sync release): wr_ptr=rd_ptr=0, count=0, out_valid=0, in_ready=1,
//    illegal_op=0. out_data/out_opcode/out_zero read 0 while empty. Storage array is not cleared.
//  - Push when in_valid & in_ready (and entry not dropped): mem[wr_ptr]<= {opcode,final_result};
//    wr_ptr wraps DEPTH-1 -> 0.
//  - Pop when out_valid & out_ready: rd_ptr increments, wraps DEPTH-1 -> 0.
//  - Latency: entry pushed at edge N is visible on out_* after edge N; no same-cycle bypass.
//  - in_ready = (count != DEPTH). out_valid = (count != 0). Both are derived from registered
//    count only, with no combinational path from out_ready.
//  - count: +1 on push only, -1 on pop only, unchanged on push+pop.
//  - Full: push blocked even if a pop occurs the same cycle; in_ready is low.
//  - Empty: no pop possible; out_* outputs forced to 0.
//  - Simultaneous push+pop when 0<count<DEPTH: both pointers advance, count holds.
//  - Producer must hold opcode/final_result stable while in_valid & !in_ready.
//  - Reset mid-operation discards all entries; the first push after release lands in slot 0.
//  - No arithmetic on data; 4-bit values are stored verbatim.
// CONFIGURATION
//  - ILLEGAL_TRAP_EN defined:
//    - An accepted beat with opcode==3'h6 is not written; the pointers and count do not change.
//    - illegal_op pulses high for exactly the cycle after acceptance.
//    - in_ready still gates acceptance, so the trap cannot fire while the FIFO is full.
//  - ILLEGAL_TRAP_EN undefined:
//    - opcode 3'h6 is stored like any other opcode.
//    - illegal_op is tied to 0.
// TESTING
//  1. Reset with rst_n=0 mid-stream (count=3) -> count=0, out_valid=0, in_ready=1 immediately,
//     without waiting for a clock edge.
//  2. Push 4'h5/op0, 4'hA/op1, 4'h0/op7, 4'hF/op2 with out_ready=0 -> count=4, in_ready=0.
//     A fifth push 4'h3 is ignored.
//  3. Drain the FIFO from test 2 with out_ready=1 -> out_data sequence 5, A, 0, F.
//     out_opcode sequence 0, 1, 7, 2. out_zero=1 only on the third entry. Then out_valid=0.
//  4. Hold count=2 with continuous push+pop for 8 cycles -> count stays 2, FIFO order is
//     preserved, and both pointers wrap twice.
//  5. Full FIFO, assert in_valid and out_ready together -> one pop, no push, count=3.
//     in_ready=1 on the next cycle.
//  6. Push opcode 3'h6, data 4'h9:
//     - ILLEGAL_TRAP_EN: illegal_op=1 for one cycle, count unchanged.
//     - Without the macro: entry is stored, illegal_op=0.

Source files
------------

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - ALU result output FIFO with valid/ready head, zero flag and occupancy
// Optional macro ILLEGAL_TRAP_EN: drop accepted beats carrying reserved opcode 3'h6 and pulse illegal_op.
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    opcode,
    input  logic [3:0]    final_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_data,
    output logic [2:0]    out_opcode,
    output logic          out_zero,
    output logic [AW:0]   count,
    output logic          illegal_op
);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [6:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [6:0]    head;
    logic          accept;
    logic          drop;
    logic          push;
    logic          pop;

    // Handshake flags come only from the registered count, never from out_ready.
    assign in_ready  = (count != FULL_COUNT);
    assign out_valid = (count != '0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign push      = accept & ~drop;

`ifdef ILLEGAL_TRAP_EN
    localparam logic [2:0] RESERVED_OP = 3'h6;

    assign drop = accept & (opcode == RESERVED_OP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= drop;
        end
    end
`else
    assign drop       = 1'b0;
    assign illegal_op = 1'b0;
`endif

    // Storage is deliberately left out of reset; empty-state outputs are masked instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {opcode, final_result};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head       = mem[rd_ptr];
    assign out_data   = out_valid ? head[3:0] : 4'h0;
    assign out_opcode = out_valid ? head[6:4] : 3'h0;
    assign out_zero   = out_valid & (head[3:0] == 4'h0);

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb/tb_alu_result_fifo.sv - randomized and directed bench for alu_result_fifo against a queue model
module tb_alu_result_fifo;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    opcode = 3'h0;
    logic [3:0]    final_result = 4'h0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [3:0]    out_data;
    logic [2:0]    out_opcode;
    logic          out_zero;
    logic [AW:0]   count;
    logic          illegal_op;

    int checks = 0;
    int errors = 0;

    logic [6:0] q[$];
    logic       m_illegal = 1'b0;

    alu_result_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .final_result(final_result), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_opcode(out_opcode),
        .out_zero(out_zero), .count(count), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one beat, advance the queue model at the edge, return just after it.
    task automatic step(input logic iv, input logic [2:0] op, input logic [3:0] d, input logic ordy);
        bit acc;
        bit pp;
        in_valid     = iv;
        opcode       = op;
        final_result = d;
        out_ready    = ordy;
        acc = iv && (q.size() != DEPTH);
        pp  = ordy && (q.size() != 0);
        @(posedge clk);
        m_illegal = 1'b0;
        if (pp) void'(q.pop_front());
        if (acc) begin
            if (TRAP && op == 3'h6) m_illegal = 1'b1;
            else q.push_back({op, d});
        end
        #1;
    endtask

    always @(negedge clk) begin : compare
        logic [6:0] h;
        bit ne;
        if (rst_n) begin
            ne = (q.size() != 0);
            h  = ne ? q[0] : 7'h0;
            chk("count", 32'(count), q.size());
            chk("out_valid", 32'(out_valid), 32'(ne));
            chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
            chk("out_data", 32'(out_data), 32'(h[3:0]));
            chk("out_opcode", 32'(out_opcode), 32'(h[6:4]));
            chk("out_zero", 32'(out_zero), 32'(ne && h[3:0] == 4'h0));
            chk("illegal_op", 32'(illegal_op), 32'(m_illegal));
        end
    end

    initial begin : drive
        logic [3:0] exp_d [4];
        logic [2:0] exp_o [4];
        logic       exp_z [4];
        logic       riv;
        logic [2:0] rop;
        logic [3:0] rd;
        logic       rrdy;
        exp_d = '{4'h5, 4'hA, 4'h0, 4'hF};
        exp_o = '{3'd0, 3'd1, 3'd7, 3'd2};
        exp_z = '{1'b0, 1'b0, 1'b1, 1'b0};

        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_illegal", 32'(illegal_op), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill to full, then an extra beat that must be ignored.
        step(1'b1, 3'd0, 4'h5, 1'b0);
        step(1'b1, 3'd1, 4'hA, 1'b0);
        step(1'b1, 3'd7, 4'h0, 1'b0);
        step(1'b1, 3'd2, 4'hF, 1'b0);
        chk("full_count", 32'(count), 4);
        chk("full_in_ready", 32'(in_ready), 0);
        step(1'b1, 3'd3, 4'h3, 1'b0);
        chk("fifth_count", 32'(count), 4);
        chk("fifth_head", 32'(out_data), 5);

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", 32'(out_data), 32'(exp_d[i]));
            chk("drain_op", 32'(out_opcode), 32'(exp_o[i]));
            chk("drain_zero", 32'(out_zero), 32'(exp_z[i]));
            step(1'b0, 3'd0, 4'h0, 1'b1);
        end
        chk("drained_valid", 32'(out_valid), 0);
        chk("drained_data", 32'(out_data), 0);

        // Steady push+pop at count 2; eight advances wrap both pointers twice.
        step(1'b1, 3'd1, 4'h1, 1'b0);
        step(1'b1, 3'd2, 4'h2, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'b1);
            chk("steady_count", 32'(count), 2);
        end

        // Full with push+pop together: pop only.
        step(1'b1, 3'd3, 4'h4, 1'b0);
        step(1'b1, 3'd4, 4'h5, 1'b0);
        chk("refill_count", 32'(count), 4);
        step(1'b1, 3'd5, 4'h6, 1'b1);
        chk("fullpp_count", 32'(count), 3);
        chk("fullpp_in_ready", 32'(in_ready), 1);

        // Reserved opcode.
        step(1'b1, 3'd6, 4'h9, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        chk("trap_pulse", 32'(illegal_op), 1);
        chk("trap_count", 32'(count), 3);
        step(1'b0, 3'd0, 4'h0, 1'b0);
        chk("trap_pulse_end", 32'(illegal_op), 0);
`else
        chk("op6_illegal", 32'(illegal_op), 0);
        chk("op6_count", 32'(count), 4);
        step(1'b0, 3'd0, 4'h0, 1'b0);
`endif

        // Asynchronous reset mid-stream at count 3.
        for (int i = 0; i < 8 && q.size() > 0; i++) step(1'b0, 3'd0, 4'h0, 1'b1);
        step(1'b1, 3'd1, 4'h7, 1'b0);
        step(1'b1, 3'd2, 4'h8, 1'b0);
        step(1'b1, 3'd3, 4'h9, 1'b0);
        chk("pre_reset_count", 32'(count), 3);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        q.delete();
        m_illegal = 1'b0;
        #1;
        chk("async_count", 32'(count), 0);
        chk("async_out_valid", 32'(out_valid), 0);
        chk("async_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 3'd5, 4'hC, 1'b0);
        chk("post_reset_data", 32'(out_data), 12);
        chk("post_reset_count", 32'(count), 1);

        // Randomized traffic; a stalled beat is held stable.
        riv = 1'b0;
        rop = 3'd0;
        rd  = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            if (!(riv && q.size() == DEPTH)) begin
                riv = ($urandom_range(0, 3) != 0);
                rop = 3'($urandom_range(0, 7));
                rd  = 4'($urandom_range(0, 15));
            end
            rrdy = ($urandom_range(0, 99) < (((i / 500) % 2) != 0 ? 25 : 75));
            step(riv, rop, rd, rrdy);
        end

        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
